// File: rtl/snap_phase_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snap_phase_capture_ctrl
// Brief    : Arm/trigger controller that writes phase samples into the
//            snapPhase BRAM and builds the software status word.
//            Optional macro SNAP_CIRC_EN selects circular pre-trigger capture.
// Revision : 1.0
// ============================================================================
module snap_phase_capture_ctrl #(
   parameter int ADDR_W   = 11,
   parameter int DATA_W   = 32,
   parameter int POST_LEN = 1024
) (
   input  logic              user_clk,
   input  logic              user_rst_n,
   input  logic              arm,
   input  logic              trig,
   input  logic              din_valid,
   input  logic [DATA_W-1:0] phase_in,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_din,
   output logic [31:0]       status_word
);

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   state_t              state_q, state_d;
   logic                arm_dly_q;
   logic [ADDR_W:0]     count_q, count_d;
   logic                we_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   din_d;
   logic [31:0]         status_d;
   logic                arm_rise;
   logic [ADDR_W:0]     count_inc;
   logic [ADDR_W:0]     count_sat;

   assign arm_rise  = arm & ~arm_dly_q;
   assign count_inc = count_q + 1'b1;
   assign count_sat = (count_q == DEPTH) ? count_q : count_inc;

`ifdef SNAP_CIRC_EN
   localparam logic [ADDR_W:0] POST_C = (ADDR_W+1)'(POST_LEN);

   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
   logic [ADDR_W:0]     post_q, post_d;
   logic [ADDR_W:0]     post_inc;

   assign post_inc = post_q + 1'b1;
`else
   localparam int POST_LEN_UNUSED = POST_LEN;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      we_d    = 1'b0;
      addr_d  = bram_addr;
      din_d   = bram_din;
`ifdef SNAP_CIRC_EN
      ptr_d       = ptr_q;
      post_d      = post_q;
      trig_addr_d = trig_addr_q;
`endif
      if (arm_rise) begin
         state_d = ARMED;
         count_d = '0;
`ifdef SNAP_CIRC_EN
         ptr_d       = '0;
         post_d      = '0;
         trig_addr_d = '0;
`endif
      end else begin
         case (state_q)
            ARMED: begin
`ifdef SNAP_CIRC_EN
               if (din_valid) begin
                  we_d    = 1'b1;
                  addr_d  = ptr_q;
                  din_d   = phase_in;
                  ptr_d   = ptr_q + 1'b1;
                  count_d = count_sat;
               end
               // Trigger address is where the trigger-cycle sample lands (or would land).
               if (trig) begin
                  trig_addr_d = ptr_q;
                  post_d      = din_valid ? (ADDR_W+1)'(1) : '0;
                  state_d     = (din_valid && POST_C == (ADDR_W+1)'(1)) ? DONE : CAPTURE;
               end
`else
               if (trig) begin
                  state_d = CAPTURE;
                  if (din_valid) begin
                     we_d    = 1'b1;
                     addr_d  = count_q[ADDR_W-1:0];
                     din_d   = phase_in;
                     count_d = count_inc;
                  end
               end
`endif
            end
            CAPTURE: begin
               if (din_valid) begin
                  we_d  = 1'b1;
                  din_d = phase_in;
`ifdef SNAP_CIRC_EN
                  addr_d  = ptr_q;
                  ptr_d   = ptr_q + 1'b1;
                  count_d = count_sat;
                  post_d  = post_inc;
                  if (post_inc == POST_C) state_d = DONE;
`else
                  addr_d  = count_q[ADDR_W-1:0];
                  count_d = count_inc;
                  if (count_inc == DEPTH) state_d = DONE;
`endif
               end
            end
            default: ;
         endcase
      end

      status_d        = '0;
      status_d[31]    = (state_d == DONE);
      status_d[30]    = (state_d == ARMED) || (state_d == CAPTURE);
      status_d[29]    = (state_d == CAPTURE);
`ifdef SNAP_CIRC_EN
      status_d[28:16] = 13'(trig_addr_d);
`endif
      status_d[12:0]  = 13'(count_d);
   end

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         state_q     <= IDLE;
         arm_dly_q   <= 1'b0;
         count_q     <= '0;
         bram_we     <= 1'b0;
         bram_addr   <= '0;
         bram_din    <= '0;
         status_word <= '0;
`ifdef SNAP_CIRC_EN
         ptr_q       <= '0;
         post_q      <= '0;
         trig_addr_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         arm_dly_q   <= arm;
         count_q     <= count_d;
         bram_we     <= we_d;
         bram_addr   <= addr_d;
         bram_din    <= din_d;
         status_word <= status_d;
`ifdef SNAP_CIRC_EN
         ptr_q       <= ptr_d;
         post_q      <= post_d;
         trig_addr_q <= trig_addr_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_snap_phase_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_snap_phase_capture_ctrl
// Brief    : Scoreboard bench for snap_phase_capture_ctrl (ADDR_W=4, POST_LEN=4).
// Revision : 1.0
// ============================================================================
module tb_snap_phase_capture_ctrl;

   localparam int ADDR_W   = 4;
   localparam int DATA_W   = 32;
   localparam int POST_LEN = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              arm, trig, din_valid;
   logic [DATA_W-1:0] phase_in;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_din;
   logic [31:0]       status_word;

   snap_phase_capture_ctrl #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .POST_LEN(POST_LEN)
   ) dut (
      .user_clk   (clk),
      .user_rst_n (rst_n),
      .arm        (arm),
      .trig       (trig),
      .din_valid  (din_valid),
      .phase_in   (phase_in),
      .bram_we    (bram_we),
      .bram_addr  (bram_addr),
      .bram_din   (bram_din),
      .status_word(status_word)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      logic [31:0]       status;
      int                cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [31:0] s);
      exp_t e;
      e.addr   = a;
      e.data   = d;
      e.status = s;
      e.cyc    = cyc + 1;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic a, input logic t, input logic v, input logic [31:0] d);
      arm       = a;
      trig      = t;
      din_valid = v;
      phase_in  = d;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] lin_status(input int a);
      return (a == 15) ? 32'h8000_0010 : (32'h6000_0000 | 32'(a + 1));
   endfunction

   // Monitor: every write the DUT presents must match the head of the queue.
   always @(negedge clk) begin
      if (bram_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", bram_addr, bram_din);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("wr_addr",   64'(bram_addr),   64'(e.addr));
            check("wr_data",   64'(bram_din),    64'(e.data));
            check("wr_status", 64'(status_word), 64'(e.status));
            check("wr_cycle",  64'(cyc),         64'(e.cyc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      arm       = 1'b1;
      trig      = 1'b0;
      din_valid = 1'b1;
      phase_in  = 32'h55;
      repeat (3) @(posedge clk);
      #1;
      check("reset_status", 64'(status_word), 64'h0);
      check("reset_we",     64'(bram_we),     64'h0);
      check("reset_addr",   64'(bram_addr),   64'h0);
      arm   = 1'b0;
      rst_n = 1'b1;
      drive(0, 0, 0, 0);

      drive(0, 1, 1, 32'h11);
      drive(0, 1, 1, 32'h12);
      check("idle_trig_status", 64'(status_word), 64'h0);

`ifndef SNAP_CIRC_EN
      drive(1, 0, 0, 0);
      check("armed_status", 64'(status_word), 64'h4000_0000);
      for (int i = 0; i < 16; i++) begin
         expect_wr(ADDR_W'(i), 32'hA0 + 32'(i), lin_status(i));
         drive(1, i == 0, 1, 32'hA0 + 32'(i));
      end
      drive(1, 0, 1, 32'hEE);
      drive(1, 0, 1, 32'hEF);
      check("linear_done_status", 64'(status_word), 64'h8000_0010);
      check("linear_drained", 64'(exp_q.size()), 64'h0);

      drive(1, 1, 1, 32'h77);
      drive(1, 1, 1, 32'h78);
      check("done_trig_status", 64'(status_word), 64'h8000_0010);

      drive(0, 0, 0, 0);
      drive(1, 0, 0, 0);
      for (int i = 0; i < 32; i++) begin
         if (i % 2 == 0) expect_wr(ADDR_W'(i / 2), 32'hB0 + 32'(i / 2), lin_status(i / 2));
         drive(1, i == 0, i % 2 == 0, 32'hB0 + 32'(i / 2));
      end
      drive(1, 0, 0, 0);
      check("stall_done_status", 64'(status_word), 64'h8000_0010);
      check("stall_drained", 64'(exp_q.size()), 64'h0);

      drive(0, 0, 0, 0);
      drive(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         expect_wr(ADDR_W'(i), 32'hC0 + 32'(i), lin_status(i));
         drive(1, i == 0, 1, 32'hC0 + 32'(i));
      end
      drive(0, 0, 0, 0);
      drive(1, 0, 1, 32'hDD);
      check("rearm_status", 64'(status_word), 64'h4000_0000);
      for (int i = 0; i < 3; i++) begin
         expect_wr(ADDR_W'(i), 32'hD0 + 32'(i), lin_status(i));
         drive(1, i == 0, 1, 32'hD0 + 32'(i));
      end
      drive(1, 0, 0, 0);
      check("rearm_capture_status", 64'(status_word), 64'h6000_0003);
      check("rearm_drained", 64'(exp_q.size()), 64'h0);

      rst_n = 1'b0;
      arm   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(0, 1, 1, 32'hF0);
      drive(0, 1, 1, 32'hF1);
      drive(0, 0, 1, 32'hF2);
      check("post_reset_status", 64'(status_word), 64'h0);
`else
      drive(1, 0, 0, 0);
      check("armed_status", 64'(status_word), 64'h4000_0000);
      for (int i = 0; i < 20; i++) begin
         expect_wr(ADDR_W'(i % 16), 32'h100 + 32'(i),
                   32'h4000_0000 | 32'((i + 1 > 16) ? 16 : i + 1));
         drive(1, 0, 1, 32'h100 + 32'(i));
      end
      check("circ_pre_status", 64'(status_word), 64'h4000_0010);
      for (int k = 0; k < 4; k++) begin
         expect_wr(ADDR_W'(4 + k), 32'h114 + 32'(k),
                   (k == 3) ? 32'h8004_0010 : 32'h6004_0010);
         drive(1, k == 0, 1, 32'h114 + 32'(k));
      end
      drive(1, 0, 1, 32'h1EE);
      drive(1, 1, 1, 32'h1EF);
      check("circ_done_status", 64'(status_word), 64'h8004_0010);
      check("circ_drained", 64'(exp_q.size()), 64'h0);
`endif

      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      check("final_drained", 64'(exp_q.size()), 64'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
